// File: rtl/contador_arbiter.sv
// Shared-counter arbiter: grants one requester at a time, counts 0..term, pulses done.
// Define CONTADOR_ARB_RR_EN for round-robin selection; fixed lowest-index priority otherwise.
//
// state | meaning
// IDLE  | no grant; pick a winner when any req is high
// LOAD  | grant held, counter cleared
// COUNT | counter runs up to the latched terminal count
// DONE  | one-cycle completion pulse, grant released on exit
module contador_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [CW-1:0]        cnt,
    output logic                 rco
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_busy;
    logic            r_rco;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_term;

    logic [IW-1:0]   w_base;
    logic [IW-1:0]   w_hi_idx;
    logic [IW-1:0]   w_lo_idx;
    logic [IW-1:0]   w_sel;
    logic            w_hi_found;
    logic            w_any;
    logic [CW-1:0]   w_len;
    logic [NREQ-1:0] w_onehot;
    logic            w_abort;

`ifdef CONTADOR_ARB_RR_EN
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_win;

    assign w_base = r_last;

    // Pointer moves to the finished (or aborted) winner so the next search starts above it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last <= IW'(NREQ-1);
            r_win  <= '0;
        end else begin
            if (r_state == IDLE && w_any)
                r_win <= w_sel;
            if (r_state == DONE || ((r_state == LOAD || r_state == COUNT) && w_abort))
                r_last <= r_win;
        end
    end
`else
    // Searching above the top index finds nothing, so selection falls to the lowest request.
    assign w_base = IW'(NREQ-1);
`endif

    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_any      = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = IW'(i);
                w_any    = 1'b1;
                if (IW'(i) > w_base) begin
                    w_hi_idx   = IW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign w_sel    = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;

    always_comb begin
        w_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == w_sel)
                w_len = len[i*CW +: CW];
        end
    end

    assign w_abort = (req & r_gnt) == '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_rco   <= 1'b0;
            r_cnt   <= '0;
            r_term  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= '0;
                    r_rco  <= 1'b0;
                    if (w_any) begin
                        r_gnt   <= w_onehot;
                        r_term  <= w_len;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_rco   <= (r_term == '0);
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (w_abort) begin
                        r_gnt   <= '0;
                        r_rco   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == r_term) begin
                        r_rco   <= 1'b0;
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_rco <= ((r_cnt + CW'(1)) == r_term);
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign cnt  = r_cnt;
    assign rco  = r_rco;

endmodule

// File: tb/tb_contador_arbiter.sv
// Directed bench for contador_arbiter (NREQ=4, CW=2); selection checks follow CONTADOR_ARB_RR_EN.
module tb_contador_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] len;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [1:0] cnt;
    logic       rco;

    int n_checks = 0;
    int n_errors = 0;

    contador_arbiter #(.NREQ(4), .CW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .cnt   (cnt),
        .rco   (rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g [5];
    logic [3:0] hold;
    logic [3:0] prev_gnt;
    int         ng;
    int         nd;

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        len   = 8'h00;

        repeat (5) tick();
        check("reset_state", {gnt, done, busy, cnt, rco}, 12'h000);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("idle_%0d", k), {gnt, done, busy, cnt, rco}, 12'h000);
        end

        // single request, term 2
        len = 8'b00_00_00_10;
        req = 4'b0001;
        tick();
        check("t2_gnt", {gnt, busy}, {4'b0001, 1'b1});
        tick();
        check("t2_c0", {cnt, rco}, {2'd0, 1'b0});
        tick();
        check("t2_c1", {cnt, rco}, {2'd1, 1'b0});
        tick();
        check("t2_c2", {gnt, cnt, rco}, {4'b0001, 2'd2, 1'b1});
        tick();
        check("t2_done", {done, rco, cnt}, {4'b0001, 1'b0, 2'd2});
        req = 4'b0000;
        tick();
        check("t2_idle", {gnt, done, busy, rco}, 10'h000);

        // max term, len changed after grant must not matter, no wrap
        len = 8'b00_00_00_11;
        req = 4'b0001;
        tick();
        check("t3_gnt", gnt, 4'b0001);
        len = 8'h00;
        tick();
        check("t3_c0", {cnt, rco}, {2'd0, 1'b0});
        tick();
        tick();
        check("t3_c2", {cnt, rco}, {2'd2, 1'b0});
        tick();
        check("t3_c3", {cnt, rco}, {2'd3, 1'b1});
        tick();
        check("t3_done", {done, cnt, rco}, {4'b0001, 2'd3, 1'b0});
        req = 4'b0000;
        tick();

        // non-winner raised mid-grant is ignored; then abort in LOAD
        len = 8'b00_01_00_00;
        req = 4'b0100;
        tick();
        check("nw_gnt", gnt, 4'b0100);
        req = 4'b0101;
        tick();
        check("nw_hold", gnt, 4'b0100);
        tick();
        check("nw_rco", {cnt, rco}, {2'd1, 1'b1});
        tick();
        check("nw_done", done, 4'b0100);
        req = 4'b0001;
        tick();
        check("nw_gap", {gnt, busy}, 5'h00);
        tick();
        check("nw_next", gnt, 4'b0001);
        req = 4'b0000;
        tick();
        check("ab_load", {gnt, done, busy, rco}, 10'h000);
        tick();

        // abort in COUNT at cnt=1
        len = 8'b00_11_00_00;
        req = 4'b0100;
        tick();
        tick();
        tick();
        check("ab_c1", {gnt, cnt}, {4'b0100, 2'd1});
        req = 4'b0000;
        tick();
        check("ab_count", {gnt, done, busy, rco}, 10'h000);
        tick();
        check("ab_nodone", {done, rco}, 5'h00);

        // reset mid-COUNT, then regrant after one idle cycle
        len = 8'b00_00_00_11;
        req = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        check("rs_c2", cnt, 2'd2);
        reset = 1'b0;
        tick();
        check("rs_zero", {gnt, done, busy, cnt, rco}, 12'h000);
        reset = 1'b1;
        tick();
        check("rs_regrant", {gnt, busy}, {4'b0001, 1'b1});
        req = 4'b0000;
        tick();
        tick();

        // held requests: arbitration order
        reset = 1'b0;
        tick();
        reset = 1'b1;
        len = 8'h00;
`ifdef CONTADOR_ARB_RR_EN
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        hold  = 4'b1111;
`else
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        hold  = 4'b0110;
`endif
        req = hold;
        prev_gnt = gnt;
        ng = 0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                if (ng < 5)
                    check($sformatf("ord_gnt_%0d", ng), gnt, exp_g[ng]);
                ng++;
            end
            if (done != 4'b0000) begin
                if (nd < 5)
                    check($sformatf("ord_done_%0d", nd), done, exp_g[nd]);
                nd++;
            end
            prev_gnt = gnt;
        end
        check("ord_ngrants", ng, 5);
        check("ord_ndone", nd, 5);
        req = 4'b0000;
        repeat (4) tick();
        check("final_idle", {gnt, done, busy, rco}, 10'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
